au_add_serial: RTL and testbench
================================

AU_ADD_SERIAL -- requirements
Module: AU_add_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand word length (>= 1).
REQ-002 The block SHALL have parameter DIGIT, default 1, bits added per cycle (1 to WIDTH).
REQ-003 The block SHALL have parameter ARCH, default 0, prefix carry architecture of the internal DIGIT-bit adder (0 to 2).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1, clock, rising edge active.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1, operands a/b/ci valid.
REQ-008 The block SHALL have port in_ready, output, 1, block can accept operands.
REQ-009 The block SHALL have port a, input, WIDTH, addend.
REQ-010 The block SHALL have port b, input, WIDTH, addend.
REQ-011 The block SHALL have port ci, input, 1, carry in.
REQ-012 The block SHALL have port out_valid, output, 1, result valid.
REQ-013 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-014 The block SHALL have port s, output, WIDTH, sum.
REQ-015 The block SHALL have port co, output, 1, carry out.

Function
REQ-016 The block SHALL compute {co, s} = a + b + ci, unsigned, exact in WIDTH+1 bits.
REQ-017 The block SHALL process N = ceil(WIDTH/DIGIT) digits, LSB digit first, one digit per clock; the carry between digits is registered.
REQ-018 The block SHALL zero-pad the final partial digit when WIDTH mod DIGIT != 0; co SHALL equal the carry out of bit WIDTH-1, not out of the padded digit.
REQ-019 The block SHALL implement states IDLE, BUSY, DONE.
REQ-020 The block SHALL drive in_ready = 1 in IDLE, = out_ready in DONE, = 0 in BUSY.
REQ-021 The block SHALL accept operands on a rising edge where in_valid and in_ready are both 1, capturing a, b, ci and entering BUSY with digit counter 0.
REQ-022 The block SHALL, in BUSY, compute one digit per edge; after the Nth digit edge it SHALL enter DONE; hence out_valid rises exactly N cycles after the accepting edge.
REQ-023 The block SHALL hold out_valid = 1, s and co stable throughout DONE until an edge with out_ready = 1.
REQ-024 The block SHALL, on a DONE edge with out_ready = 1: enter BUSY with new operands if in_valid = 1 (back-to-back, no bubble), otherwise enter IDLE.
REQ-025 The block SHALL ignore in_valid, a, b, ci on edges where in_ready = 0; operands need not be held after acceptance.
REQ-026 The block SHALL ignore out_ready outside DONE.
REQ-027 The block SHALL keep s and co unchanged from the last result while in IDLE and BUSY; only the transition into DONE updates them.
REQ-028 When DIGIT = WIDTH (N = 1), the block SHALL spend exactly one cycle in BUSY.

Reset
REQ-029 The block SHALL, while rst = 1, immediately force state IDLE, digit counter 0, carry register 0, out_valid = 0, in_ready = 0, s = 0, co = 0.
REQ-030 The block SHALL, on rst assertion mid-BUSY or in DONE, discard the operation in progress; no result is ever presented for it.
REQ-031 The block SHALL drive in_ready = 1 from the first cycle after rst deasserts.

Verification
REQ-032 WIDTH=8, DIGIT=3: accept a=0xFF, b=0x01, ci=0 -> out_valid exactly 3 cycles later, s=0x00, co=1.
REQ-033 WIDTH=8, DIGIT=3: a=0x7F, b=0x80, ci=1 -> s=0x00, co=1; a=0x12, b=0x34, ci=0 -> s=0x46, co=0.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> s, co, out_valid stable, in_ready=0; out_ready=1 with in_valid=1 -> new operation accepted the same edge, next result 3 cycles later.
REQ-035 Reset at digit 1 of BUSY -> out_valid=0, s=0, co=0 immediately; no stale result after rst release; a fresh operation returns the correct sum.
REQ-036 WIDTH=8, DIGIT=8 and WIDTH=1, DIGIT=1: 1-cycle latency; a=1, b=1, ci=1 (WIDTH=1) -> s=1, co=1; randomized 1000 ops vs. reference a+b+ci for DIGIT in {1,3,8}.

Source files
------------

// File: rtl/au_add_serial_if.sv
// Operand/result handshake bundle for the digit-serial adder.
// The master side supplies operands and consumes results; the slave side is the adder.
interface au_add_serial_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;

    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, s, co
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, s, co
    );
endinterface

// File: rtl/au_add_serial.sv
// Digit-serial unsigned adder: {co, s} = a + b + ci, DIGIT bits per clock, LSB digit first.
// The DIGIT-bit stage uses a selectable parallel-prefix carry network (0 ripple, 1 Kogge-Stone, 2 Sklansky).
module au_add_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1,
    parameter int unsigned ARCH  = 0
) (
    input logic             clk,
    input logic             rst,
    au_add_serial_if.slave  bus
);
    localparam int unsigned N  = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int unsigned PW = N * DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned M  = DIGIT + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [PW-1:0]     opa_q, opa_d;
    logic [PW-1:0]     opb_q, opb_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              co_q, co_d;
    logic              out_valid_q, out_valid_d;

    logic              in_ready;
    logic              accept;
    logic [M-1:0]      g, p, gg, pp, ng, np;
    logic [DIGIT-1:0]  dsum;
    logic              dcout;
    logic [PW-1:0]     acc_step;
    logic [PW:0]       full;

    // Element 0 of the prefix vector carries the registered inter-digit carry.
    always_comb begin
        g  = {opa_q[DIGIT-1:0] & opb_q[DIGIT-1:0], carry_q};
        p  = {opa_q[DIGIT-1:0] ^ opb_q[DIGIT-1:0], 1'b0};
        gg = g;
        pp = p;
        ng = g;
        np = p;
        if (ARCH == 0) begin
            for (int i = 1; i < int'(M); i++) begin
                gg[i] = gg[i] | (pp[i] & gg[i-1]);
            end
        end else if (ARCH == 1) begin
            for (int d = 1; d < int'(M); d = d * 2) begin
                ng = gg;
                np = pp;
                for (int i = d; i < int'(M); i++) begin
                    ng[i] = gg[i] | (pp[i] & gg[i-d]);
                    np[i] = pp[i] & pp[i-d];
                end
                gg = ng;
                pp = np;
            end
        end else begin
            for (int d = 1; d < int'(M); d = d * 2) begin
                ng = gg;
                np = pp;
                for (int i = 0; i < int'(M); i++) begin
                    if ((i & d) != 0) begin
                        ng[i] = gg[i] | (pp[i] & gg[(i & ~(d - 1)) - 1]);
                        np[i] = pp[i] & pp[(i & ~(d - 1)) - 1];
                    end
                end
                gg = ng;
                pp = np;
            end
        end
        dsum  = p[M-1:1] ^ gg[M-2:0];
        dcout = gg[M-1];
    end

    // Padded bits have p=0, so bit WIDTH of the padded sum is the carry out of bit WIDTH-1.
    assign acc_step = PW'({dsum, acc_q} >> DIGIT);
    assign full     = {dcout, acc_step};

    assign in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        s_d         = s_q;
        co_d        = co_q;
        out_valid_d = out_valid_q;
        case (state_q)
            BUSY: begin
                acc_d   = acc_step;
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                carry_d = dcout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    s_d         = full[WIDTH-1:0];
                    co_d        = full[WIDTH];
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        // Acceptance overrides the DONE->IDLE exit for back-to-back operation.
        if (accept) begin
            state_d = BUSY;
            cnt_d   = '0;
            carry_d = bus.ci;
            opa_d   = PW'(bus.a);
            opb_d   = PW'(bus.b);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            s_q         <= '0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            s_q         <= s_d;
            co_q        <= co_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.co        = co_q;
endmodule

// File: tb/tb_au_add_serial.sv
// Lockstep bench for six adder configurations sharing one operand stream.
// Instances: 0..2 = W8/D3 (ARCH 0,1,2), 3 = W8/D1, 4 = W8/D8, 5 = W1/D1.
module tb_au_add_serial;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       ci = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    int         checks = 0;
    int         failures = 0;
    int         exp_lat [6] = '{3, 3, 3, 8, 1, 1};

    always #5 clk = ~clk;

    au_add_serial_if #(.WIDTH(8)) i0 ();
    au_add_serial_if #(.WIDTH(8)) i1 ();
    au_add_serial_if #(.WIDTH(8)) i2 ();
    au_add_serial_if #(.WIDTH(8)) i3 ();
    au_add_serial_if #(.WIDTH(8)) i4 ();
    au_add_serial_if #(.WIDTH(1)) i5 ();

    assign i0.in_valid = in_valid; assign i0.a = a; assign i0.b = b; assign i0.ci = ci; assign i0.out_ready = out_ready;
    assign i1.in_valid = in_valid; assign i1.a = a; assign i1.b = b; assign i1.ci = ci; assign i1.out_ready = out_ready;
    assign i2.in_valid = in_valid; assign i2.a = a; assign i2.b = b; assign i2.ci = ci; assign i2.out_ready = out_ready;
    assign i3.in_valid = in_valid; assign i3.a = a; assign i3.b = b; assign i3.ci = ci; assign i3.out_ready = out_ready;
    assign i4.in_valid = in_valid; assign i4.a = a; assign i4.b = b; assign i4.ci = ci; assign i4.out_ready = out_ready;
    assign i5.in_valid = in_valid; assign i5.a = a[0]; assign i5.b = b[0]; assign i5.ci = ci; assign i5.out_ready = out_ready;

    au_add_serial #(.WIDTH(8), .DIGIT(3), .ARCH(0)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
    au_add_serial #(.WIDTH(8), .DIGIT(3), .ARCH(1)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
    au_add_serial #(.WIDTH(8), .DIGIT(3), .ARCH(2)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));
    au_add_serial #(.WIDTH(8), .DIGIT(1), .ARCH(1)) u3 (.clk(clk), .rst(rst), .bus(i3.slave));
    au_add_serial #(.WIDTH(8), .DIGIT(8), .ARCH(2)) u4 (.clk(clk), .rst(rst), .bus(i4.slave));
    au_add_serial #(.WIDTH(1), .DIGIT(1), .ARCH(0)) u5 (.clk(clk), .rst(rst), .bus(i5.slave));

    logic [5:0] ov, ir;
    logic [8:0] res [6];
    assign ov = {i5.out_valid, i4.out_valid, i3.out_valid, i2.out_valid, i1.out_valid, i0.out_valid};
    assign ir = {i5.in_ready, i4.in_ready, i3.in_ready, i2.in_ready, i1.in_ready, i0.in_ready};
    assign res[0] = {i0.co, i0.s};
    assign res[1] = {i1.co, i1.s};
    assign res[2] = {i2.co, i2.s};
    assign res[3] = {i3.co, i3.s};
    assign res[4] = {i4.co, i4.s};
    assign res[5] = {7'b0, i5.co, i5.s};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Called at the negedge after the accepting edge; e8 = {co,s} for 8-bit, e1 = {co,s} for 1-bit.
    task automatic wait_check(input logic [8:0] e8, input logic [1:0] e1, input bit rel);
        int lat [6];
        int n;
        for (int k = 0; k < 6; k++) lat[k] = -1;
        n = 0;
        forever begin
            for (int k = 0; k < 6; k++) if (ov[k] && lat[k] < 0) lat[k] = n;
            if (ov == 6'h3f || n >= 30) break;
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 6; k++) chk($sformatf("latency_u%0d", k), lat[k], exp_lat[k]);
        for (int k = 0; k < 5; k++) chk($sformatf("sum_u%0d", k), res[k], e8);
        chk("sum_u5", res[5], {30'b0, e1});
        if (rel) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk("idle_after_release", ov, 6'h00);
        end
    endtask

    task automatic op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tci,
                      input logic [8:0] e8, input logic [1:0] e1, input bit rel);
        in_valid = 1'b1; a = ta; b = tb_v; ci = tci;
        chk("ready_before_accept", ir, 6'h3f);
        @(negedge clk);
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        wait_check(e8, e1, rel);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;

        repeat (2) @(negedge clk);
        chk("reset_out_valid", ov, 6'h00);
        chk("reset_in_ready", ir, 6'h00);
        chk("reset_sum_u0", res[0], 9'h000);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", ir, 6'h3f);
        @(negedge clk);

        op(8'hFF, 8'h01, 1'b0, 9'h100, 2'b10, 1'b1);
        op(8'h7F, 8'h80, 1'b1, 9'h100, 2'b10, 1'b1);
        op(8'h12, 8'h34, 1'b0, 9'h046, 2'b00, 1'b1);
        op(8'h01, 8'h01, 1'b1, 9'h003, 2'b11, 1'b0);

        // Backpressure: hold results in DONE.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", ov, 6'h3f);
            chk("bp_sum_u0", res[0], 9'h003);
            chk("bp_in_ready", ir, 6'h00);
        end
        out_ready = 1'b1; in_valid = 1'b1; a = 8'h55; b = 8'h0F; ci = 1'b1;
        #1;
        chk("b2b_in_ready", ir, 6'h3f);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_no_bubble", ov, 6'h00);
        chk("b2b_old_sum_kept", res[0], 9'h003);
        wait_check(9'h065, 2'b11, 1'b1);

        // Reset at digit 1 of BUSY.
        in_valid = 1'b1; a = 8'hC8; b = 8'h64; ci = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", ov, 6'h00);
        chk("midrst_sum_u0", res[0], 9'h000);
        chk("midrst_in_ready", ir, 6'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_stale_result", ov, 6'h00);
        end
        op(8'hC8, 8'h64, 1'b0, 9'h12C, 2'b00, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            op(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), 2'(ra[0]) + 2'(rb[0]) + 2'(rc), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
